// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, instruction register, one-bubble redirect, halt and return stack.
// Define FETCH_LINK_STACK_EN for a STACK_DEPTH-entry return stack; otherwise a single link register.
module fetch_stage #(
  parameter int unsigned       ADDR_W      = 8,
  parameter int unsigned       INSTR_W     = 16,
  parameter int unsigned       STACK_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0
) (
  input  logic               clk,
  input  logic               rst,
  output logic [ADDR_W-1:0]  mem_a,
  input  logic [INSTR_W-1:0] mem_ri,
  output logic [INSTR_W-1:0] ir,
  output logic [ADDR_W-1:0]  ir_pc,
  output logic               ir_valid,
  input  logic               ir_ready,
  input  logic               br_take,
  input  logic [ADDR_W-1:0]  br_target,
  input  logic               br_link,
  input  logic               br_ret,
  input  logic               halt,
  output logic [ADDR_W-1:0]  pc,
  output logic               halted,
  output logic               stk_ovf,
  output logic               stk_unf
);

  if (STACK_DEPTH < 2 || (STACK_DEPTH & (STACK_DEPTH - 1)) != 0) begin : g_depth_chk
    $error("fetch_stage: STACK_DEPTH must be a power of two and at least 2");
  end

  typedef enum logic [1:0] {S_RUN, S_BUBBLE, S_HALT} state_t;

  state_t             r_state, w_state_nxt;
  logic [ADDR_W-1:0]  r_pc, w_pc_nxt;
  logic [INSTR_W-1:0] r_ir, w_ir_nxt;
  logic [ADDR_W-1:0]  r_ir_pc, w_ir_pc_nxt;
  logic               r_ir_valid, w_ir_valid_nxt;
  logic               w_consume;
  logic               w_load;
  logic               w_push;
  logic [ADDR_W-1:0]  w_pop_val;
  logic [ADDR_W-1:0]  w_link_val;

  assign w_consume  = r_ir_valid && ir_ready;
  assign w_link_val = r_ir_pc + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_RUN;
      r_pc       <= RESET_PC;
      r_ir       <= '0;
      r_ir_pc    <= '0;
      r_ir_valid <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_ir       <= w_ir_nxt;
      r_ir_pc    <= w_ir_pc_nxt;
      r_ir_valid <= w_ir_valid_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_ir_nxt       = r_ir;
    w_ir_pc_nxt    = r_ir_pc;
    w_ir_valid_nxt = r_ir_valid;
    w_push         = 1'b0;
    w_load         = 1'b0;
    case (r_state)
      S_RUN: begin
        if (w_consume && halt) begin
          w_ir_valid_nxt = 1'b0;
          w_state_nxt    = S_HALT;
        end else if (w_consume && br_ret) begin
          w_pc_nxt       = w_pop_val;
          w_ir_valid_nxt = 1'b0;
          w_state_nxt    = S_BUBBLE;
        end else if (w_consume && br_take) begin
          w_push         = br_link;
          w_pc_nxt       = br_target;
          w_ir_valid_nxt = 1'b0;
          w_state_nxt    = S_BUBBLE;
        end else if (!r_ir_valid || ir_ready) begin
          w_load = 1'b1;
        end
      end
      S_BUBBLE: begin
        w_load      = 1'b1;
        w_state_nxt = S_RUN;
      end
      S_HALT: begin
        w_state_nxt = S_HALT;
      end
      default: begin
        w_state_nxt = S_RUN;
      end
    endcase
    if (w_load) begin
      w_ir_nxt       = mem_ri;
      w_ir_pc_nxt    = r_pc;
      w_ir_valid_nxt = 1'b1;
      w_pc_nxt       = r_pc + 1'b1;
    end
  end

`ifdef FETCH_LINK_STACK_EN
  localparam int unsigned     PTR_W   = $clog2(STACK_DEPTH);
  localparam logic [PTR_W:0]  DEPTH_C = (PTR_W + 1)'(STACK_DEPTH);

  logic [ADDR_W-1:0] r_stk [STACK_DEPTH];
  logic [PTR_W:0]    r_cnt;
  logic [PTR_W-1:0]  w_top_idx;
  logic              w_pop;
  logic              w_empty;
  logic              w_full;
  logic              r_ovf, r_unf;

  // Same priority as the FSM: a return is only accepted when halt is absent.
  assign w_pop     = (r_state == S_RUN) && w_consume && !halt && br_ret;
  assign w_empty   = (r_cnt == '0);
  assign w_full    = (r_cnt == DEPTH_C);
  assign w_top_idx = r_cnt[PTR_W-1:0] - 1'b1;
  assign w_pop_val = w_empty ? RESET_PC : r_stk[w_top_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
      for (int unsigned i = 0; i < STACK_DEPTH; i++) begin
        r_stk[i] <= '0;
      end
    end else begin
      if (w_pop) begin
        if (w_empty) r_unf <= 1'b1;
        else         r_cnt <= r_cnt - 1'b1;
      end
      if (w_push) begin
        if (w_full) begin
          r_ovf <= 1'b1;
        end else begin
          r_stk[r_cnt[PTR_W-1:0]] <= w_link_val;
          r_cnt                   <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign stk_ovf = r_ovf;
  assign stk_unf = r_unf;
`else
  logic [ADDR_W-1:0] r_link;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_link <= RESET_PC;
    else if (w_push) r_link <= w_link_val;
  end

  assign w_pop_val = r_link;
  assign stk_ovf   = 1'b0;
  assign stk_unf   = 1'b0;
`endif

  assign mem_a    = r_pc;
  assign pc       = r_pc;
  assign ir       = r_ir;
  assign ir_pc    = r_ir_pc;
  assign ir_valid = r_ir_valid;
  assign halted   = (r_state == S_HALT);

endmodule
